// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin, burst-bounded arbiter sharing one FIFO write port.
//            Optional fixed priority for requester 0 when FIFO_ARB_PRIO_EN
//            is defined.
// Revision : 1.0 - initial release
//==============================================================================
module fifo_wr_arbiter #(
   parameter int DATO_WIDTH = 3,
   parameter int N_REQ      = 3,
   parameter int BURST_MAX  = 4
) (
   input  logic                        wclk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*DATO_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            ack,
   output logic [N_REQ-1:0]            grant,
   input  logic                        fifo_full,
   output logic                        fifo_wr,
   output logic [DATO_WIDTH-1:0]       fifo_din,
   output logic                        busy
);

   localparam int         c_LW         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [3:0] c_BURST_LAST = 4'(BURST_MAX - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic [c_LW-1:0]     r_last;

   logic [c_LW-1:0]     w_win_idx;
   logic [c_LW-1:0]     w_owner;
   logic [DATO_WIDTH-1:0] w_din;
   logic                w_found;
   logic                w_own_req;
   logic                w_preempt;
   logic                w_leave;
   int                  w_cand;

   // Search upward from last+1 so the most recent owner is served last.
   always_comb begin
      w_win_idx = '0;
      w_found   = 1'b0;
      w_cand    = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_cand = int'(r_last) + k;
         if (w_cand >= N_REQ) w_cand = w_cand - N_REQ;
         if (!w_found && req[w_cand]) begin
            w_found   = 1'b1;
            w_win_idx = c_LW'(w_cand);
         end
      end
`ifdef FIFO_ARB_PRIO_EN
      if (req[0]) w_win_idx = '0;
`endif
   end

   always_comb begin
      w_owner = '0;
      w_din   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            w_owner = c_LW'(i);
            w_din   = w_din | req_data[i*DATO_WIDTH +: DATO_WIDTH];
         end
      end
   end

   assign w_own_req = |(grant & req);
   assign fifo_wr   = (r_state == ST_WRITE) && w_own_req && !fifo_full;
   assign fifo_din  = w_din;
   assign ack       = grant & {N_REQ{fifo_wr}};
   assign busy      = (r_state == ST_WRITE);

`ifdef FIFO_ARB_PRIO_EN
   // Requester 0 cuts another owner's burst short, even while stalled on full.
   assign w_preempt = (r_state == ST_WRITE) && !grant[0] && req[0];
`else
   assign w_preempt = 1'b0;
`endif

   assign w_leave = (fifo_wr && (r_cnt == c_BURST_LAST)) || !w_own_req || w_preempt;

   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         grant   <= '0;
         r_cnt   <= '0;
         r_last  <= c_LW'(N_REQ - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  grant   <= N_REQ'(1) << w_win_idx;
                  r_cnt   <= '0;
                  r_state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (fifo_wr) r_cnt <= r_cnt + 4'd1;
               if (w_leave) begin
                  r_state <= ST_IDLE;
                  grant   <= '0;
                  r_cnt   <= '0;
                  r_last  <= w_owner;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               grant   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed self-checking bench for fifo_wr_arbiter (3 req, burst 4).
// Revision : 1.0 - initial release
//==============================================================================
module tb_fifo_wr_arbiter;

   logic       wclk;
   logic       rst;
   logic [2:0] req;
   logic [8:0] req_data;
   logic [2:0] ack;
   logic [2:0] grant;
   logic       fifo_full;
   logic       fifo_wr;
   logic [2:0] fifo_din;
   logic       busy;

   int checks = 0;
   int errors = 0;

   fifo_wr_arbiter #(
      .DATO_WIDTH (3),
      .N_REQ      (3),
      .BURST_MAX  (4)
   ) dut (
      .wclk      (wclk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .ack       (ack),
      .grant     (grant),
      .fifo_full (fifo_full),
      .fifo_wr   (fifo_wr),
      .fifo_din  (fifo_din),
      .busy      (busy)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   logic [2:0] exp_g [4];

   initial begin
      exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
      rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Idle after reset
      for (int c = 0; c < 5; c++) begin
         #1;
         check("idle_grant", grant, 3'b000);
         check("idle_wr",    fifo_wr, 1'b0);
         check("idle_busy",  busy, 1'b0);
         check("idle_ack",   ack, 3'b000);
         check("idle_din",   fifo_din, 3'd0);
         tick();
      end

      // Single requester, full burst of 4
      req = 3'b001; req_data = {3'd0, 3'd0, 3'd5};
      #1;
      check("arb_wr", fifo_wr, 1'b0);
      check("arb_busy", busy, 1'b0);
      tick();
      for (int w = 0; w < 4; w++) begin
         check("b0_grant", grant, 3'b001);
         check("b0_wr", fifo_wr, 1'b1);
         check("b0_ack", ack, 3'b001);
         check("b0_din", fifo_din, 3'd5);
         tick();
      end
      check("b0_gap_grant", grant, 3'b000);
      check("b0_gap_wr", fifo_wr, 1'b0);
      tick();
      check("b0_regrant", grant, 3'b001);
      req = 3'b000;
      #1;
      check("drop_wr", fifo_wr, 1'b0);
      check("drop_ack", ack, 3'b000);
      tick();
      check("drop_release", grant, 3'b000);
      check("drop_busy", busy, 1'b0);

      // Asynchronous reset restores last = n_req-1
      rst = 1'b1; #1; rst = 1'b0;
      req_data = {3'd3, 3'd2, 3'd1};

`ifndef FIFO_ARB_PRIO_EN
      // Round robin with all requesters active
      req = 3'b111;
      for (int b = 0; b < 4; b++) begin
         #1;
         check("rr_gap_busy", busy, 1'b0);
         check("rr_gap_wr", fifo_wr, 1'b0);
         tick();
         for (int w = 0; w < 4; w++) begin
            check("rr_grant", grant, exp_g[b]);
            check("rr_ack", ack, exp_g[b]);
            check("rr_din", fifo_din, (exp_g[b] == 3'b001) ? 3'd1 : (exp_g[b] == 3'b010) ? 3'd2 : 3'd3);
            tick();
         end
      end

      // Stall on full mid-burst (owner 010), burst still totals 4
      check("st_idle", grant, 3'b000);
      tick();
      check("st_grant", grant, 3'b010);
      check("st_wr1", fifo_wr, 1'b1);
      tick();
      fifo_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("st_full_wr", fifo_wr, 1'b0);
         check("st_full_ack", ack, 3'b000);
         check("st_full_grant", grant, 3'b010);
         check("st_full_busy", busy, 1'b1);
         tick();
      end
      fifo_full = 1'b0;
      for (int w = 0; w < 3; w++) begin
         #1;
         check("st_res_wr", fifo_wr, 1'b1);
         check("st_res_ack", ack, 3'b010);
         tick();
      end
      check("st_end_grant", grant, 3'b000);
      tick();

      // Full and owner req drop together: release without write
      check("fd_grant", grant, 3'b100);
      fifo_full = 1'b1; req = 3'b011;
      #1;
      check("fd_wr", fifo_wr, 1'b0);
      tick();
      check("fd_release", grant, 3'b000);
      fifo_full = 1'b0; req = 3'b111;
      rst = 1'b1; #1; rst = 1'b0;
`endif

      // Reset during second write of a burst
      req = 3'b111;
      tick();
      check("rb_grant", grant, 3'b001);
      tick();
      #1;
      check("rb_wr2", fifo_wr, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rb_rst_wr", fifo_wr, 1'b0);
      check("rb_rst_ack", ack, 3'b000);
      check("rb_rst_grant", grant, 3'b000);
      check("rb_rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick();
      check("rb_regrant", grant, 3'b001);

`ifdef FIFO_ARB_PRIO_EN
      // Requester 0 preempts owner 100 after the current write
      rst = 1'b1; #1; rst = 1'b0;
      req = 3'b100;
      tick();
      check("pr_grant", grant, 3'b100);
      req = 3'b101;
      #1;
      check("pr_wr", fifo_wr, 1'b1);
      check("pr_ack", ack, 3'b100);
      tick();
      check("pr_release", grant, 3'b000);
      check("pr_busy", busy, 1'b0);
      tick();
      check("pr_grant0", grant, 3'b001);
`endif

      req = 3'b000;
      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of one FIFO between n_req independent producers.
- Round-robin grant with bounded bursts: a granted producer may push up to burst_max consecutive words before the grant rotates.
- Obeys the FIFO full flag, so no write is ever issued into a full FIFO.
- Sits on the write-clock side, directly in front of the FIFO wr/datin/full pins.

Parameters:
- dato_width, 3, width of one data word (must match the FIFO).
- n_req, 3, number of requesters (2..8).
- burst_max, 4, maximum words written per grant (1..15).

Ports:
- wclk  in  1  write-side clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  n_req  per-requester request; held high while that requester has a word on its data slice.
- req_data  in  n_req*dato_width  flattened data; requester i uses bits [i*dato_width +: dato_width].
- ack  out  n_req  one-hot, combinational; high in the cycle requester i's word is written.
- grant  out  n_req  registered one-hot owner of the write port; 0 when idle.
- fifo_full  in  1  full flag from the FIFO.
- fifo_wr  out  1  combinational write strobe to the FIFO.
- fifo_din  out  dato_width  combinational data to the FIFO.
- busy  out  1  high while in state WRITE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, grant=0, burst_cnt=0, last=n_req-1, so requester 0 has first priority.
  - fifo_wr=0, ack=0, busy=0; fifo_din is driven with 0 while grant=0.
- State machine, two states, IDLE and WRITE:
  - IDLE: if any req bit is set, the winner is the first set bit searching upward from last+1 modulo n_req. Next edge: grant<=onehot(winner), burst_cnt<=0, state<=WRITE. If no req bit is set, stay in IDLE.
  - Arbitration therefore costs exactly one cycle; first write happens no earlier than 1 cycle after req rises.
  - WRITE, owner g:
    - fifo_wr = req[g] & ~fifo_full.
    - fifo_din = slice g of req_data.
    - ack = grant & {n_req{fifo_wr}}.
  - Each edge with fifo_wr=1: burst_cnt <= burst_cnt+1.
  - Leave WRITE (state<=IDLE, grant<=0, last<=g) on the edge where either:
    - fifo_wr=1 and burst_cnt==burst_max-1, or
    - req[g]=0.
  - fifo_full=1 in WRITE: stall, with no write, no ack and burst_cnt held. Grant is kept, and writing resumes the cycle full drops.
- Handshake: a requester changes req_data (or drops req) only after an edge on which its ack was high. It may drop req at any time; the grant is then released on the next edge.
- Simultaneous events:
  - full and req[g] drop in the same cycle: release, no write.
  - A non-owner's req is ignored until the next IDLE.
- burst_cnt is 4 bits; it never exceeds burst_max-1, so there is no wrap.
- Reset mid-burst: the in-flight word is not written (fifo_wr falls asynchronously) and no ack is issued for it.
- Throughput: at most burst_max words per burst, then one idle arbitration cycle.

Optional Feature:
- Macro FIFO_ARB_PRIO_EN.
- Defined: requester 0 is fixed high priority. In IDLE, if req[0]=1, requester 0 wins regardless of last. In WRITE, when another requester owns the port and req[0] is high, the burst ends early after its current write; if the owner is stalled on full, the grant is released with no write.
- Not defined: pure round-robin exactly as in Behaviour; req[0] has no special role.

Test Plan:
- rst=1 then 0, req=0 for 5 cycles -> grant=0, fifo_wr=0, busy=0, ack=0 throughout.
- req=3'b001, data0=5 held, fifo_full=0, burst_max=4 -> grant=001 after 1 cycle; 4 writes of 5 with ack=001 each cycle; then 1 IDLE cycle; then re-grant 001.
- req=3'b111 constant, burst_max=4 -> grant sequence 001,010,100,001; each burst is 4 writes, with 1 IDLE cycle between bursts.
- Owner 010 writing, fifo_full=1 for 3 cycles mid-burst -> fifo_wr=0 and ack=0 for those 3 cycles, grant stays 010, burst resumes and totals 4 writes.
- rst pulsed asynchronously (mid-cycle) during the 2nd write of a burst -> fifo_wr drops immediately, grant=0, last=n_req-1; next arbitration with req=111 grants 001.
- FIFO_ARB_PRIO_EN defined, owner 100 with req[0] rising -> after the current write grant releases, 1 IDLE cycle, then grant=001.
